dual_port_ram_ctrl: RTL
=======================

Name: dual_port_ram_ctrl

Overview:
- Parametrised true dual-port synchronous RAM; successor to the fixed 8x64 dual-port RAM.
- Adds the following over the fixed block:
  - configurable width and depth
  - per-port enable and byte enables
  - selectable read-during-write mode
  - optional output pipeline register
  - hardware memory-clear sequencer with ready flag
  - write-write collision detection and arbitration
- Sits between two independent masters (e.g. DMA and CPU) sharing one buffer.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- WR_MODE, 0, same-port read-during-write:
  - 0 = read-first (q gets old data)
  - 1 = write-first (q gets new data)
  - 2 = no-change (q holds)
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  pulse; starts memory clear when rdy=1
- rdy  out  1  1 = clear complete, ports accept requests
- en_a  in  1  port A access enable
- we_a  in  1  port A write (valid with en_a)
- be_a  in  DATA_W/8  port A byte enables, bit i covers data[8i+7:8i]
- addr_a  in  ADDR_W  port A address
- data_a  in  DATA_W  port A write data
- q_a  out  DATA_W  port A read data
- valid_a  out  1  q_a holds the data for a completed read
- en_b, we_b, be_b, addr_b, data_b, q_b, valid_b: identical for port B
- collision  out  1  one-cycle pulse on a same-address dual write

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset rst_n is asynchronous, active-low.
  - On reset: q_a=q_b=0, valid_a=valid_b=0, rdy=0, collision=0, FSM enters CLEAR with clear pointer=0.
  - Array contents are not flop-reset; the CLEAR state zeroes them.
- FSM has two states, CLEAR and READY:
  - CLEAR writes 0 to address ptr, one word per cycle; ptr increments.
  - ptr = DEPTH-1 written -> READY next cycle; rdy=1 from that cycle. Clear takes DEPTH cycles.
  - In CLEAR, all en_a/en_b requests are dropped: no writes, valid stays 0.
  - READY & clr=1 -> CLEAR with ptr=0; rdy drops the next cycle.
  - clr in CLEAR is ignored.
  - rst_n asserted mid-clear -> restart from ptr=0.
- Read (READY, en=1, we=0):
  - OUT_REG=0: q and valid=1 on the next edge.
  - OUT_REG=1: one edge later.
  - valid is a single-cycle pulse per read; q holds its last value otherwise.
- Write (READY, en=1, we=1):
  - Only bytes with be=1 are updated; be=0 leaves the word unchanged.
  - Writes never assert valid.
  - Read data returned on a write cycle depends on WR_MODE:
    - 0: q gets the pre-write word.
    - 1: q gets the post-write word (merged with be).
    - 2: q unchanged.
    - Modes 0 and 1 also pulse valid.
- Cross-port read of an address the other port writes in the same cycle: returns the old word.
- Both ports write the same address in the same cycle:
  - Per byte: port A wins where be_a=1, port B bytes apply only where be_a=0 and be_b=1.
  - collision pulses 1 cycle, aligned with the write edge +1.
  - Identical addresses with only one port writing: no collision.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.

Optional Feature:
- Macro: DUAL_PORT_RAM_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per byte, computed on write; CLEAR writes parity 0.
  - Adds outputs par_err_a and par_err_b (DATA_W/8 bits each).
  - par_err bits are asserted together with valid for each byte whose stored parity mismatches; 0 otherwise; reset 0.
  - Adds input inj_par (1 bit): when 1 on a write, byte 0 parity is stored inverted, for test.
- Undefined: no parity storage, ports par_err_a, par_err_b and inj_par absent.

Test Plan (DATA_W=16, ADDR_W=6, OUT_REG=0 unless stated):
- Reset release -> rdy=0 for exactly 64 cycles, then rdy=1; read every address on A and B -> all 0x0000 with valid pulses.
- A writes 0xBEEF @0x05 be=11; next cycle B reads 0x05 -> q_b=0xBEEF, valid_b=1 one cycle later; then A writes 0x1200 be=10 @0x05, read -> 0x12EF.
- Same-port read-during-write @0x07 (old 0x1111, write 0x2222), WR_MODE=0/1/2:
  - mode 0: q=0x1111
  - mode 1: q=0x2222
  - mode 2: q unchanged, valid_a=0
- A writes 0xAAAA be=01, B writes 0x5555 be=11 @0x10 same cycle -> collision=1 for one cycle; read -> 0x55AA.
- clr pulse while READY, then write during CLEAR @0x03 -> rdy low 64 cycles, write dropped, @0x03 reads 0x0000; rst_n low at ptr=20 -> rdy low a full 64 cycles after release.
- OUT_REG=1: read @0x05 -> valid_a at edge +2. With DUAL_PORT_RAM_PARITY_EN, write with inj_par=1 then read -> par_err_a=01 with valid_a.

Source files
------------

// File: rtl/dual_port_ram_ctrl.sv
// dual_port_ram_ctrl: parametrised true dual-port synchronous RAM with byte
// enables, selectable read-during-write mode, optional output register,
// power-up/commanded memory clear and write-write collision arbitration.
// Optional feature macro: DUAL_PORT_RAM_PARITY_EN (per-byte even parity).
//
// state   | meaning
// S_CLEAR | zeroing one word per cycle at ptr, requests dropped, rdy=0
// S_READY | both ports serve requests, rdy=1
module dual_port_ram_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6,
  parameter int WR_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                rdy,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   data_a,
  output logic [DATA_W-1:0]   q_a,
  output logic                valid_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   data_b,
  output logic [DATA_W-1:0]   q_b,
  output logic                valid_b,
  output logic                collision
`ifdef DUAL_PORT_RAM_PARITY_EN
  ,
  input  logic                inj_par,
  output logic [DATA_W/8-1:0] par_err_a,
  output logic [DATA_W/8-1:0] par_err_b
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              state, state_nxt;
  logic                clearing;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_a, wr_a, rd_b, wr_b, same, ld_a, ld_b;
  logic [DATA_W-1:0]   old_a, old_b, mask_a, mask_b, mask_bc;
  logic [DATA_W-1:0]   word_a, own_b, word_b, ldq_a, ldq_b;
  logic [DATA_W-1:0]   q1_a, q1_b;
  logic                v1_a, v1_b;

  function automatic logic [DATA_W-1:0] byte_mask(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // State register; reset always restarts the clear from address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    clearing  = 1'b0;
    case (state)
      S_CLEAR: begin
        clearing = 1'b1;
        if (ptr == '1) state_nxt = S_READY;
      end
      S_READY: begin
        rdy = 1'b1;
        if (clr) state_nxt = S_CLEAR;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Clear pointer: advances while clearing, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr <= '0;
    else if (clearing) ptr <= ptr + 1'b1;
    else               ptr <= '0;
  end

  assign rd_a  = rdy & en_a & ~we_a;
  assign wr_a  = rdy & en_a & we_a;
  assign rd_b  = rdy & en_b & ~we_b;
  assign wr_b  = rdy & en_b & we_b;
  assign same  = wr_a & wr_b & (addr_a == addr_b);

  assign old_a   = mem[addr_a];
  assign old_b   = mem[addr_b];
  assign mask_a  = byte_mask(be_a);
  assign mask_b  = byte_mask(be_b);
  // On a same-address collision port B only fills bytes port A leaves alone
  assign mask_bc = byte_mask(be_b & ~be_a);
  assign word_a  = (old_a & ~mask_a) | (data_a & mask_a);
  assign own_b   = (old_b & ~mask_b) | (data_b & mask_b);
  assign word_b  = same ? ((word_a & ~mask_bc) | (data_b & mask_bc)) : own_b;

  // Write-first returns the port's own merged word; otherwise the old word
  assign ld_a  = rd_a | (wr_a & (WR_MODE != 2));
  assign ld_b  = rd_b | (wr_b & (WR_MODE != 2));
  assign ldq_a = (wr_a && WR_MODE == 1) ? word_a : old_a;
  assign ldq_b = (wr_b && WR_MODE == 1) ? own_b  : old_b;

  // Array update; B is written last so its merged word carries A's bytes
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[ptr] <= '0;
    end else begin
      if (wr_a) mem[addr_a] <= word_a;
      if (wr_b) mem[addr_b] <= word_b;
    end
  end

  // First read stage: q holds between loads, valid is a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_a <= '0;
      q1_b <= '0;
      v1_a <= 1'b0;
      v1_b <= 1'b0;
    end else begin
      v1_a <= ld_a;
      v1_b <= ld_b;
      if (ld_a) q1_a <= ldq_a;
      if (ld_b) q1_b <= ldq_b;
    end
  end

  // Collision flag registered so it appears right after the write edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= same;
  end

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [NB-1:0] pmem [DEPTH];
  logic [NB-1:0] pold_a, pold_b, pnew_a, pnew_b, pown_a, pown_b, pw_b;
  logic [NB-1:0] lde_a, lde_b, e1_a, e1_b, eo_a, eo_b;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

  assign pold_a = pmem[addr_a];
  assign pold_b = pmem[addr_b];
  assign pnew_a = byte_par(data_a) ^ NB'(inj_par);
  assign pnew_b = byte_par(data_b) ^ NB'(inj_par);
  assign pown_a = (pold_a & ~be_a) | (pnew_a & be_a);
  assign pown_b = (pold_b & ~be_b) | (pnew_b & be_b);
  assign pw_b   = same ? ((pown_a & ~(be_b & ~be_a)) | (pnew_b & be_b & ~be_a)) : pown_b;
  assign lde_a  = (wr_a && WR_MODE == 1) ? (byte_par(word_a) ^ pown_a) : (byte_par(old_a) ^ pold_a);
  assign lde_b  = (wr_b && WR_MODE == 1) ? (byte_par(own_b)  ^ pown_b) : (byte_par(old_b) ^ pold_b);

  // Parity array follows the data array write for write
  always_ff @(posedge clk) begin
    if (clearing) begin
      pmem[ptr] <= '0;
    end else begin
      if (wr_a) pmem[addr_a] <= pown_a;
      if (wr_b) pmem[addr_b] <= pw_b;
    end
  end

  // Parity error captured alongside the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_a <= '0;
      e1_b <= '0;
    end else begin
      if (ld_a) e1_a <= lde_a;
      if (ld_b) e1_b <= lde_b;
    end
  end

  assign par_err_a = valid_a ? eo_a : '0;
  assign par_err_b = valid_b ? eo_b : '0;
`endif

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] q2_a, q2_b;
    logic              v2_a, v2_b;
    // Second stage delays data and valid by one more edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q2_a <= '0;
        q2_b <= '0;
        v2_a <= 1'b0;
        v2_b <= 1'b0;
      end else begin
        v2_a <= v1_a;
        v2_b <= v1_b;
        if (v1_a) q2_a <= q1_a;
        if (v1_b) q2_b <= q1_b;
      end
    end
    assign q_a     = q2_a;
    assign q_b     = q2_b;
    assign valid_a = v2_a;
    assign valid_b = v2_b;
`ifdef DUAL_PORT_RAM_PARITY_EN
    logic [NB-1:0] e2_a, e2_b;
    // Parity error tracks the delayed data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e2_a <= '0;
        e2_b <= '0;
      end else begin
        if (v1_a) e2_a <= e1_a;
        if (v1_b) e2_b <= e1_b;
      end
    end
    assign eo_a = e2_a;
    assign eo_b = e2_b;
`endif
  end else begin : g_no_reg
    assign q_a     = q1_a;
    assign q_b     = q1_b;
    assign valid_a = v1_a;
    assign valid_b = v1_b;
`ifdef DUAL_PORT_RAM_PARITY_EN
    assign eo_a = e1_a;
    assign eo_b = e1_b;
`endif
  end

endmodule
